hub75_line_rx: RTL and testbench
================================

Name: hub75_line_rx

Overview:
- Receiving end of the HUB75 panel drive interface (CLK/LAT/RGB01/ABC).
- Oversamples panel-side signals in the system clock domain and shifts in 64 columns of 6-bit RGB per scanline.
- On LAT, moves the captured line to a holding buffer and streams it out as per-pixel write strobes (line, col, rgb).
- Used as a frame-buffer sniffer for a chained panel, and as the checker that closes the loop on the panel driver in system test.

Parameters:
- COLS, 64: columns shifted per latched scanline.
- LINE_BITS, 3: width of ABC scanline selector.
- SYNC_STAGES, 2: synchronizer depth on all hub_* inputs (≥2).

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- hub_clk  input  1  panel shift clock, asynchronous to clk_in.
- hub_lat  input  1  panel latch.
- hub_rgb  input  6  {R1,G1,B1,R0,G0,B0} panel data.
- hub_abc  input  LINE_BITS  scanline select.
- pix_valid  output  1  pixel write strobe.
- pix_line  output  LINE_BITS  scanline of pixel.
- pix_col  output  6  column of pixel.
- pix_rgb  output  6  pixel data.
- frame_start  output  1  pulse with the first pix_valid of line 0.
- short_line  output  1  1-cycle pulse: latch seen with fewer than COLS shift clocks.
- overrun  output  1  1-cycle pulse: valid latch arrived while still draining.

Behaviour:
- Reset: all outputs 0, shift count 0, state IDLE, buffers don't-care. Reset mid-drain aborts the drain; no further pix_valid until a new valid line is latched.
- Input sampling:
  - hub_clk, hub_lat, hub_rgb and hub_abc each pass through SYNC_STAGES flops.
  - Rising edges are detected on the synchronized clk and lat, using one extra history flop each.
  - Data is used at the same synchronizer depth as the clock.
  - Input requirement: rgb/abc stable ≥2 clk_in cycles around the hub_clk/hub_lat rise; hub_clk high and low ≥2 clk_in cycles each.
- Shift path:
  - Each synchronized hub_clk rise shifts rgb into a COLS×6 shift register.
  - The shift count increments and saturates at COLS. Extra clocks keep shifting, so the last COLS values are retained.
- Column mapping: the i-th value shifted after a latch (i=0 first) maps to col COLS-1-i. The last shifted value is col 0.
- Latch handling: every synchronized hub_lat rise clears the shift count. Its outcome is decided by count and state:
  - count==COLS, state IDLE: copy the shift register to the holding buffer, capture abc into pix_line, enter DRAIN.
  - count<COLS: short_line pulse, nothing copied, state unchanged.
  - count==COLS, state DRAIN: overrun pulse, new line dropped, current drain continues unchanged.
  - A clk rise coinciding with a lat rise: the shift is applied first, then the count is cleared. The shifted bit counts toward the latched line.
- States:
  - IDLE: waiting for a valid latch.
  - DRAIN: pix_valid=1 for exactly COLS consecutive cycles, pix_col=0,1,…,COLS-1, pix_rgb = holding[col]. Returns to IDLE after col COLS-1.
- Drain output rules:
  - pix_line is constant during a drain.
  - frame_start=1 only in the col-0 cycle when pix_line==0.
- Latency: hub_lat sampled high at clk_in edge N gives first pix_valid high after edge N+SYNC_STAGES+1.
- Shifting continues during DRAIN. Shift register and holding buffer are independent.

Decomposition:
- hub75_pkg holds COLS, LINE_BITS, RGB_BITS=6 and the IDLE/DRAIN state encoding.
- Sub-module hub75_sync: parametric SYNC_STAGES synchronizer with optional rising-edge output. Instantiated for clk and lat (edge) and for rgb and abc (bus, no edge).

Test Plan:
- 64 hub_clk pulses with rgb = col-index pattern (first shifted = 6'h3F … last = 6'h00), abc=3, then lat → 64 pix_valid cycles, pix_line=3, pix_col 0..63, pix_rgb==pix_col[5:0]; first pix_valid 3 cycles after lat sampled.
- abc=0 full line → frame_start high only with col 0; abc=5 full line → frame_start never asserts.
- 40 hub_clk pulses then lat → short_line one pulse, no pix_valid. Next full 64-pulse line drains normally.
- 70 clocks then lat → line accepted, holding the last 64 values (shifts 6..69).
- Second valid latch forced while draining (protocol-violating fast stimulus) → overrun pulse, first line's 64 writes intact, second line never emitted.
- reset_n low at drain col 20 → all outputs 0 asynchronously, no further writes. After release, a new full line drains from col 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared sizing constants and the drain FSM encoding for the
// HUB75 line receiver.
//   COLS      - columns shifted per latched scanline
//   LINE_BITS - width of the ABC scanline selector
//   RGB_BITS  - {R1,G1,B1,R0,G0,B0} pixel width
//   COL_BITS  - width of the pixel column output
package hub75_pkg;

  localparam int unsigned COLS      = 64;
  localparam int unsigned LINE_BITS = 3;
  localparam int unsigned RGB_BITS  = 6;
  localparam int unsigned COL_BITS  = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/hub75_line_rx_if.sv
// hub75_line_rx_if: panel-side HUB75 inputs and pixel write-strobe outputs.
//   master : panel driver / pixel consumer side (drives hub_*, reads pix_*)
//   slave  : the receiver (reads hub_*, drives pix_*)
//   hub_clk, hub_lat, hub_rgb, hub_abc      - raw panel signals
//   pix_valid, pix_line, pix_col, pix_rgb   - per-pixel write strobe
//   frame_start, short_line, overrun        - status pulses
interface hub75_line_rx_if #(
  parameter int unsigned LINE_BITS = hub75_pkg::LINE_BITS
);
  import hub75_pkg::*;

  logic                 hub_clk;
  logic                 hub_lat;
  logic [RGB_BITS-1:0]  hub_rgb;
  logic [LINE_BITS-1:0] hub_abc;

  logic                 pix_valid;
  logic [LINE_BITS-1:0] pix_line;
  logic [COL_BITS-1:0]  pix_col;
  logic [RGB_BITS-1:0]  pix_rgb;
  logic                 frame_start;
  logic                 short_line;
  logic                 overrun;

  modport master (
    output hub_clk, hub_lat, hub_rgb, hub_abc,
    input  pix_valid, pix_line, pix_col, pix_rgb, frame_start, short_line, overrun
  );

  modport slave (
    input  hub_clk, hub_lat, hub_rgb, hub_abc,
    output pix_valid, pix_line, pix_col, pix_rgb, frame_start, short_line, overrun
  );

endinterface

// File: rtl/hub75_sync.sv
// hub75_sync: SYNC_STAGES-deep synchronizer plus one history flop.
//   clk_i, rst_ni - system clock, async active-low reset
//   d_i           - asynchronous input bus
//   q_o           - synchronized value, delayed to line up with rise_o
//   rise_o        - registered per-bit rising-edge pulse (0 when EDGE=0)
module hub75_sync #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // hist_q is the same sample that rise_q reports on, so bus data taken from
  // q_o is aligned with edge pulses from a sibling instance.
  assign q_o = hist_q;

  if (EDGE) begin : g_edge
    logic [WIDTH-1:0] rise_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rise_q <= '0;
      else         rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
    assign rise_o = rise_q;
  end else begin : g_no_edge
    assign rise_o = '0;
  end

endmodule

// File: rtl/hub75_line_rx.sv
// hub75_line_rx: HUB75 scanline receiver. Oversamples the panel interface,
// shifts COLS pixels per line, and on a valid latch streams the captured
// line out as COLS consecutive pixel write strobes.
//   clk_in  - system clock
//   reset_n - async active-low reset
//   hub     - slave side of hub75_line_rx_if (hub_* in, pix_*/status out)
module hub75_line_rx #(
  parameter int unsigned COLS        = hub75_pkg::COLS,
  parameter int unsigned LINE_BITS   = hub75_pkg::LINE_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk_in,
  input  logic           reset_n,
  hub75_line_rx_if.slave hub
);
  import hub75_pkg::*;

  localparam int unsigned CNT_W = $clog2(COLS + 1);
  localparam int unsigned BUS_W = RGB_BITS + LINE_BITS;

  logic [1:0]           edge_lvl_unused;
  logic [1:0]           edge_rise;
  logic [BUS_W-1:0]     bus_s;
  logic [BUS_W-1:0]     bus_rise_unused;
  logic                 clk_rise, lat_rise;
  logic [RGB_BITS-1:0]  rgb_s;
  logic [LINE_BITS-1:0] abc_s;

  hub75_sync #(.WIDTH(2), .SYNC_STAGES(SYNC_STAGES), .EDGE(1'b1)) u_sync_edge (
    .clk_i (clk_in),
    .rst_ni(reset_n),
    .d_i   ({hub.hub_lat, hub.hub_clk}),
    .q_o   (edge_lvl_unused),
    .rise_o(edge_rise)
  );

  hub75_sync #(.WIDTH(BUS_W), .SYNC_STAGES(SYNC_STAGES), .EDGE(1'b0)) u_sync_bus (
    .clk_i (clk_in),
    .rst_ni(reset_n),
    .d_i   ({hub.hub_abc, hub.hub_rgb}),
    .q_o   (bus_s),
    .rise_o(bus_rise_unused)
  );

  assign clk_rise       = edge_rise[0];
  assign lat_rise       = edge_rise[1];
  assign {abc_s, rgb_s} = bus_s;

  logic [RGB_BITS-1:0]  shift_q [COLS];
  logic [RGB_BITS-1:0]  shift_d [COLS];
  logic [RGB_BITS-1:0]  hold_q  [COLS];
  logic [CNT_W-1:0]     cnt_q, cnt_shift;
  logic                 line_full, accept;
  state_e               state_q;
  logic                 pix_valid_q, frame_start_q, short_line_q, overrun_q;
  logic [LINE_BITS-1:0] pix_line_q;
  logic [COL_BITS-1:0]  pix_col_q, col_nxt;
  logic [RGB_BITS-1:0]  pix_rgb_q;

  // Newest sample enters at index 0, so index == column after a full line.
  always_comb begin
    shift_d = shift_q;
    if (clk_rise) begin
      shift_d[0] = rgb_s;
      for (int unsigned i = 1; i < COLS; i++) shift_d[i] = shift_q[i-1];
    end
  end

  // A shift coinciding with the latch is folded in before the count is judged.
  always_comb begin
    cnt_shift = cnt_q;
    if (clk_rise && (cnt_q != CNT_W'(COLS))) cnt_shift = cnt_q + 1'b1;
  end

  assign line_full = (cnt_shift == CNT_W'(COLS));
  assign accept    = lat_rise && line_full && (state_q == ST_IDLE);
  assign col_nxt   = pix_col_q + 1'b1;

  always_ff @(posedge clk_in) begin
    shift_q <= shift_d;
    if (accept) hold_q <= shift_d;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)      cnt_q <= '0;
    else if (lat_rise) cnt_q <= '0;
    else               cnt_q <= cnt_shift;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pix_valid_q   <= 1'b0;
      pix_line_q    <= '0;
      pix_col_q     <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      short_line_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      short_line_q  <= lat_rise && !line_full;
      overrun_q     <= lat_rise && line_full && (state_q == ST_DRAIN);
      frame_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q       <= ST_DRAIN;
            pix_valid_q   <= 1'b1;
            pix_line_q    <= abc_s;
            pix_col_q     <= '0;
            pix_rgb_q     <= shift_d[0];
            frame_start_q <= (abc_s == '0);
          end
        end
        ST_DRAIN: begin
          if (pix_col_q == COL_BITS'(COLS - 1)) begin
            state_q     <= ST_IDLE;
            pix_valid_q <= 1'b0;
            pix_col_q   <= '0;
            pix_rgb_q   <= '0;
          end else begin
            pix_col_q <= col_nxt;
            pix_rgb_q <= hold_q[col_nxt];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hub.pix_valid   = pix_valid_q;
  assign hub.pix_line    = pix_line_q;
  assign hub.pix_col     = pix_col_q;
  assign hub.pix_rgb     = pix_rgb_q;
  assign hub.frame_start = frame_start_q;
  assign hub.short_line  = short_line_q;
  assign hub.overrun     = overrun_q;

endmodule

// File: tb/tb_hub75_line_rx.sv
// tb_hub75_line_rx: directed bench for hub75_line_rx. Drives HUB75 panel
// waveforms on the falling system-clock edge and records every pixel strobe
// one time unit after the rising edge.
module tb_hub75_line_rx;

  logic clk_in  = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk_in = ~clk_in;

  hub75_line_rx_if #(.LINE_BITS(3)) hub ();

  hub75_line_rx #(.COLS(64), .LINE_BITS(3), .SYNC_STAGES(2)) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .hub    (hub)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  int unsigned cyc     = 0;
  int unsigned lat_cyc = 0;
  int unsigned n_short = 0;
  int unsigned n_ovr   = 0;
  int unsigned q_cyc[$], q_line[$], q_col[$], q_rgb[$], q_fs[$];
  int unsigned exp_rgb[64];

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  always @(posedge clk_in) begin
    #1;
    cyc++;
    if (hub.pix_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_line.push_back(int'(hub.pix_line));
      q_col.push_back(int'(hub.pix_col));
      q_rgb.push_back(int'(hub.pix_rgb));
      q_fs.push_back(int'(hub.frame_start));
    end
    if (hub.short_line === 1'b1) n_short++;
    if (hub.overrun === 1'b1)    n_ovr++;
  end

  function automatic int unsigned out_vec();
    return int'({hub.pix_valid, hub.pix_line, hub.pix_col, hub.pix_rgb,
                 hub.frame_start, hub.short_line, hub.overrun});
  endfunction

  function automatic int unsigned pix_key(input int unsigned off, line, col, rgb, fs);
    return (off << 16) | (line << 13) | (col << 7) | (rgb << 1) | fs;
  endfunction

  task automatic clear_mon();
    q_cyc.delete(); q_line.delete(); q_col.delete(); q_rgb.delete(); q_fs.delete();
    n_short = 0;
    n_ovr   = 0;
  endtask

  task automatic hub_pulse(input logic [5:0] d);
    hub.hub_rgb = d;
    repeat (2) @(negedge clk_in);
    hub.hub_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    hub.hub_clk = 1'b0;
  endtask

  task automatic latch(input logic [2:0] abc);
    hub.hub_abc = abc;
    repeat (2) @(negedge clk_in);
    hub.hub_lat = 1'b1;
    lat_cyc = cyc + 1;
    repeat (2) @(negedge clk_in);
    hub.hub_lat = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic check_drain(input string tag, input int unsigned line);
    int unsigned n_fs;
    n_fs = 0;
    chk({tag, "_count"}, q_col.size(), 64);
    for (int i = 0; i < q_col.size() && i < 64; i++) begin
      n_fs += q_fs[i];
      chk($sformatf("%s_px%0d", tag, i),
          pix_key(q_cyc[i] - q_cyc[0], q_line[i], q_col[i], q_rgb[i], q_fs[i]),
          pix_key(i, line, i, exp_rgb[i], (line == 0 && i == 0) ? 1 : 0));
    end
    chk({tag, "_fs_total"}, n_fs, (line == 0) ? 1 : 0);
  endtask

  initial begin
    int unsigned found;
    hub.hub_clk = 1'b0;
    hub.hub_lat = 1'b0;
    hub.hub_rgb = '0;
    hub.hub_abc = '0;

    repeat (2) @(negedge clk_in);
    chk("reset_outs", out_vec(), 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_in);
    chk("idle_outs", out_vec(), 0);

    // Col-index pattern on line 3, plus latch-to-first-strobe latency.
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'(63 - i));
    latch(3'd3);
    repeat (80) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = c;
    check_drain("line3", 3);
    chk("line3_latency", (q_cyc.size() > 0) ? q_cyc[0] - lat_cyc : 0, 3);
    chk("line3_short", n_short, 0);
    chk("line3_ovr", n_ovr, 0);

    // Line 0 carries frame_start on col 0 only.
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'((63 - i) ^ 42));
    latch(3'd0);
    repeat (80) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = (c ^ 42) & 63;
    check_drain("line0", 0);

    // Line 5: no frame_start anywhere.
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'((63 - i) * 5));
    latch(3'd5);
    repeat (80) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = (c * 5) & 63;
    check_drain("line5", 5);

    // Short line is flagged and dropped; the next full line is unaffected.
    clear_mon();
    for (int i = 0; i < 40; i++) hub_pulse(6'h11);
    latch(3'd1);
    repeat (80) @(negedge clk_in);
    chk("short_pulse", n_short, 1);
    chk("short_nopix", q_col.size(), 0);
    chk("short_ovr", n_ovr, 0);
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'(63 - i));
    latch(3'd2);
    repeat (80) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = c;
    check_drain("after_short", 2);
    chk("after_short_short", n_short, 0);

    // 70 shifts: shifts 6..69 retained, shift 69 is col 0.
    clear_mon();
    for (int j = 0; j < 70; j++) hub_pulse(6'(j ^ 21));
    latch(3'd6);
    repeat (80) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = ((69 - c) ^ 21) & 63;
    check_drain("long", 6);
    chk("long_short", n_short, 0);

    // A second full-count latch mid-drain. Legal HUB75 timing cannot deliver
    // 64 shift clocks inside one drain, so the shift count is forced full.
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'((63 - i) ^ 15));
    latch(3'd1);
    for (int i = 0; i < 5; i++) hub_pulse(6'h3F);
    force dut.cnt_q = 7'd64;
    latch(3'd7);
    release dut.cnt_q;
    repeat (150) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = (c ^ 15) & 63;
    check_drain("ovr_first", 1);
    chk("ovr_pulse", n_ovr, 1);
    chk("ovr_short", n_short, 0);

    // Reset at col 20 kills the drain immediately and for good.
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'(63 - i));
    latch(3'd4);
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_in);
      #2;
      if (hub.pix_valid === 1'b1 && hub.pix_col == 6'd20) begin
        found = 1;
        break;
      end
    end
    chk("rst_col20_seen", found, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", out_vec(), 0);
    chk("rst_partial_count", q_col.size(), 21);
    repeat (3) @(negedge clk_in);
    reset_n = 1'b1;
    repeat (100) @(negedge clk_in);
    chk("rst_no_resume", q_col.size(), 21);
    clear_mon();
    for (int i = 0; i < 64; i++) hub_pulse(6'((63 - i) ^ 51));
    latch(3'd7);
    repeat (80) @(negedge clk_in);
    for (int c = 0; c < 64; c++) exp_rgb[c] = (c ^ 51) & 63;
    check_drain("post_rst", 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
